// File: rtl/onehot_pkg.sv
// Shared types and helpers for the rotating one-hot bus checker.
package onehot_pkg;

  localparam int unsigned MAX_W = 64;
  localparam int unsigned IW    = 6;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  // Left-rotate by one within the low w bits; bits at or above w must be zero.
  function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] code,
                                             input int unsigned      w);
    logic [MAX_W-1:0] mask;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    return ((code << 1) | (code >> (w - 1))) & mask;
  endfunction

  function automatic logic onehot_is_valid(input logic [MAX_W-1:0] code);
    return $countones(code) == 1;
  endfunction

  // OR of set-bit positions; exact for a one-hot input.
  function automatic logic [IW-1:0] onehot_to_index(input logic [MAX_W-1:0] code);
    logic [IW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (code[i]) idx = idx | IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational one-hot validity check and binary position decode.
module onehot_decode
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             valid_c,
  output logic [IDX_W-1:0] index_c
);

  logic [MAX_W-1:0] code_ext;

  assign code_ext = MAX_W'(code);
  assign valid_c  = onehot_is_valid(code_ext);
  assign index_c  = IDX_W'(onehot_to_index(code_ext));

endmodule

// File: rtl/onehot_monitor.sv
// Receive-side checker for the rotating one-hot LED bus: rotation, dwell window,
// stall and lock tracking. All outputs registered, two clocks behind onehot_in.
module onehot_monitor
  import onehot_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned EXP_DWELL  = 50000001,
  parameter int unsigned TOL        = 2,
  parameter int unsigned LOCK_STEPS = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         onehot_in,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     code_valid,
  output logic                     step_pulse,
  output logic [CNT_W-1:0]         dwell_cycles,
  output logic                     seq_err,
  output logic                     timing_err,
  output logic                     code_err,
  output logic                     stall,
  output logic                     locked
);

  localparam int unsigned      IDX_W   = $clog2(WIDTH);
  localparam int unsigned      GS_W    = $clog2(LOCK_STEPS + 1);
  localparam logic [CNT_W-1:0] DW_LO   = CNT_W'(EXP_DWELL - TOL);
  localparam logic [CNT_W-1:0] DW_HI   = CNT_W'(EXP_DWELL + TOL);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  in_q, prev_q, prev_d, expect_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_c, dwell_d;
  logic [GS_W-1:0]   good_q, good_d, good_inc_c;
  logic              valid_c;
  logic [IDX_W-1:0]  idx_c, index_d;
  logic              change_c, correct_c, in_win_c, over_c, tracking_c, lock_reach_c;
  logic              code_valid_d, step_d, seq_d, tim_d, code_err_d, stall_d, locked_d;

  onehot_decode #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_decode (
    .code    (in_q),
    .valid_c (valid_c),
    .index_c (idx_c)
  );

  assign expect_c     = WIDTH'(rotl1(MAX_W'(prev_q), WIDTH));
  assign change_c     = valid_c && (in_q != prev_q);
  assign correct_c    = (in_q == expect_c);
  assign in_win_c     = (cnt_q >= DW_LO) && (cnt_q <= DW_HI);
  assign over_c       = (cnt_q > DW_HI);
  assign tracking_c   = (state_q == TRACK) || (state_q == LOCKED);
  assign cnt_inc_c    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign good_inc_c   = good_q + GS_W'(1);
  assign lock_reach_c = 32'(good_inc_c) >= LOCK_STEPS;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ACQUIRE;
    else        state_q <= state_d;
  end

  // Next state: an invalid sample overrides everything else
  always_comb begin
    state_d = state_q;
    if (!valid_c) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        ACQUIRE, ERROR: state_d = TRACK;
        TRACK:  if (change_c && correct_c && in_win_c && lock_reach_c) state_d = LOCKED;
        LOCKED: if (change_c ? !(correct_c && in_win_c) : over_c) state_d = TRACK;
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    prev_d       = prev_q;
    cnt_d        = cnt_inc_c;
    good_d       = good_q;
    dwell_d      = dwell_cycles;
    step_d       = 1'b0;
    seq_d        = 1'b0;
    tim_d        = 1'b0;
    stall_d      = stall;
    index_d      = valid_c ? idx_c : index;
    code_valid_d = valid_c;
    code_err_d   = !valid_c;
    locked_d     = (state_d == LOCKED);
    if (!valid_c) begin
      stall_d = 1'b0;
    end else if (!tracking_c) begin
      prev_d  = in_q;
      cnt_d   = CNT_W'(1);
      good_d  = '0;
      stall_d = 1'b0;
    end else if (change_c) begin
      prev_d  = in_q;
      cnt_d   = CNT_W'(1);
      dwell_d = cnt_q;
      stall_d = 1'b0;
      if (correct_c) begin
        step_d = 1'b1;
        if (!in_win_c) begin
          tim_d  = 1'b1;
          good_d = '0;
        end else if (state_q == TRACK) begin
          good_d = good_inc_c;
        end
      end else begin
        seq_d  = 1'b1;
        good_d = '0;
      end
    end else if (over_c && !stall) begin
      stall_d = 1'b1;
      good_d  = '0;
    end
  end

  // Sample, datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_q         <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      good_q       <= '0;
      index        <= '0;
      code_valid   <= 1'b0;
      step_pulse   <= 1'b0;
      dwell_cycles <= '0;
      seq_err      <= 1'b0;
      timing_err   <= 1'b0;
      code_err     <= 1'b0;
      stall        <= 1'b0;
      locked       <= 1'b0;
    end else begin
      in_q         <= onehot_in;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      good_q       <= good_d;
      index        <= index_d;
      code_valid   <= code_valid_d;
      step_pulse   <= step_d;
      dwell_cycles <= dwell_d;
      seq_err      <= seq_d;
      timing_err   <= tim_d;
      code_err     <= code_err_d;
      stall        <= stall_d;
      locked       <= locked_d;
    end
  end

endmodule

// File: tb/tb_onehot_monitor.sv
// Bench for onehot_monitor: directed scenarios then random codes/periods,
// every output compared each clock against a time-stamp based reference model.
module tb_onehot_monitor;

  localparam int unsigned EXP    = 10;
  localparam int unsigned TOLV   = 0;
  localparam int unsigned LSTEPS = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] onehot_in;
  logic [2:0] index;
  logic [7:0] dwell_cycles;
  logic       code_valid, step_pulse, seq_err, timing_err, code_err, stall, locked;

  int total = 0;
  int bad   = 0;
  string phase = "init";

  // Reference model: cycle time stamps instead of a counter
  int         now, tlast, good;
  bit         trk;
  logic [7:0] m_prev, mq, lastv;
  logic [2:0] e_idx;
  logic [7:0] e_dwell;
  logic       e_cv, e_step, e_seq, e_tim, e_cerr, e_stall, e_locked;

  always #5 CLK = ~CLK;

  onehot_monitor #(
    .WIDTH      (8),
    .CNT_W      (8),
    .EXP_DWELL  (EXP),
    .TOL        (TOLV),
    .LOCK_STEPS (LSTEPS)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .onehot_in    (onehot_in),
    .index        (index),
    .code_valid   (code_valid),
    .step_pulse   (step_pulse),
    .dwell_cycles (dwell_cycles),
    .seq_err      (seq_err),
    .timing_err   (timing_err),
    .code_err     (code_err),
    .stall        (stall),
    .locked       (locked)
  );

  function automatic logic [7:0] nxt(input logic [7:0] c);
    return (c == 8'h80) ? 8'h01 : 8'(c * 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s [%s] observed=%0h expected=%0h", tag, phase, obs, exp);
    end
  endtask

  task automatic model_reset();
    now = 0; tlast = 0; good = 0; trk = 0;
    m_prev = '0; mq = '0;
    e_idx = '0; e_dwell = '0;
    e_cv = 0; e_step = 0; e_seq = 0; e_tim = 0; e_cerr = 0; e_stall = 0; e_locked = 0;
  endtask

  task automatic model_step(input logic [7:0] s);
    int cnt;
    cnt = now - tlast;
    if (cnt > 255) cnt = 255;
    e_step = 0; e_seq = 0; e_tim = 0;
    if ($countones(s) != 1) begin
      e_cv = 0; e_cerr = 1; trk = 0; e_locked = 0; e_stall = 0;
    end else begin
      e_cv = 1; e_cerr = 0; e_idx = 3'($clog2(s));
      if (!trk) begin
        trk = 1; m_prev = s; tlast = now; good = 0; e_stall = 0;
      end else if (s != m_prev) begin
        e_dwell = 8'(cnt); e_stall = 0;
        if (s == nxt(m_prev)) begin
          e_step = 1;
          if (cnt >= int'(EXP - TOLV) && cnt <= int'(EXP + TOLV)) begin
            if (!e_locked) begin
              good++;
              if (good >= int'(LSTEPS)) e_locked = 1;
            end
          end else begin
            e_tim = 1; good = 0; e_locked = 0;
          end
        end else begin
          e_seq = 1; good = 0; e_locked = 0;
        end
        m_prev = s; tlast = now;
      end else if (cnt > int'(EXP + TOLV) && !e_stall) begin
        e_stall = 1; good = 0; e_locked = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("index",        32'(index),        32'(e_idx));
    chk("code_valid",   32'(code_valid),   32'(e_cv));
    chk("step_pulse",   32'(step_pulse),   32'(e_step));
    chk("dwell_cycles", 32'(dwell_cycles), 32'(e_dwell));
    chk("seq_err",      32'(seq_err),      32'(e_seq));
    chk("timing_err",   32'(timing_err),   32'(e_tim));
    chk("code_err",     32'(code_err),     32'(e_cerr));
    chk("stall",        32'(stall),        32'(e_stall));
    chk("locked",       32'(locked),       32'(e_locked));
  endtask

  task automatic tick();
    @(posedge CLK);
    now++;
    model_step(mq);
    mq = onehot_in;
    #1;
    compare_all();
  endtask

  task automatic hold(input logic [7:0] c, input int n);
    onehot_in = c;
    if ($countones(c) == 1) lastv = c;
    repeat (n) tick();
  endtask

  // Asynchronous reset between clock edges, released on a falling edge
  task automatic do_reset(input logic [7:0] c);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    compare_all();
    onehot_in = c;
    lastv = c;
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  initial begin
    int r, len;
    logic [7:0] c;
    RST_N = 1'b1;
    onehot_in = '0;
    lastv = 8'h01;
    #2;
    RST_N = 1'b0;
    #1;
    phase = "reset0";
    model_reset();
    compare_all();
    onehot_in = 8'h01;
    @(negedge CLK);
    RST_N = 1'b1;
    hold(8'h01, 10);
    hold(8'h02, 10);
    hold(8'h04, 4);

    phase = "t1_midreset";
    do_reset(8'h01);
    chk("t1_rst_locked", 32'(locked), 32'd0);
    chk("t1_rst_dwell", 32'(dwell_cycles), 32'd0);
    hold(8'h01, 10);
    chk("t1_index", 32'(index), 32'd0);
    chk("t1_step", 32'(step_pulse), 32'd0);
    chk("t1_valid", 32'(code_valid), 32'd1);

    phase = "t2_rotate";
    hold(8'h02, 10);
    chk("t2_dwell", 32'(dwell_cycles), 32'd10);
    hold(8'h04, 10);
    chk("t2_not_locked", 32'(locked), 32'd0);
    hold(8'h08, 10);
    chk("t2_locked", 32'(locked), 32'd1);
    chk("t2_index", 32'(index), 32'd3);
    hold(8'h10, 10);
    hold(8'h20, 10);
    hold(8'h40, 10);
    hold(8'h80, 10);
    onehot_in = 8'h01;
    tick(); tick();
    chk("t2_wrap_step", 32'(step_pulse), 32'd1);
    chk("t2_wrap_seq", 32'(seq_err), 32'd0);
    chk("t2_wrap_index", 32'(index), 32'd0);
    repeat (8) tick();

    phase = "t3_seqerr";
    hold(8'h02, 10);
    hold(8'h04, 10);
    chk("t3_locked", 32'(locked), 32'd1);
    onehot_in = 8'h10;
    tick(); tick();
    chk("t3_seq", 32'(seq_err), 32'd1);
    chk("t3_unlock", 32'(locked), 32'd0);
    chk("t3_index", 32'(index), 32'd4);
    chk("t3_dwell", 32'(dwell_cycles), 32'd10);
    repeat (8) tick();

    phase = "t4_badcode";
    hold(8'h00, 5);
    chk("t4_zero_err", 32'(code_err), 32'd1);
    chk("t4_zero_idx", 32'(index), 32'd4);
    hold(8'h03, 5);
    chk("t4_multi_err", 32'(code_err), 32'd1);
    chk("t4_multi_valid", 32'(code_valid), 32'd0);
    onehot_in = 8'h08;
    tick(); tick();
    chk("t4_recover_valid", 32'(code_valid), 32'd1);
    chk("t4_recover_seq", 32'(seq_err), 32'd0);
    chk("t4_recover_idx", 32'(index), 32'd3);
    repeat (8) tick();

    phase = "t5_stall";
    hold(8'h10, 10);
    hold(8'h20, 10);
    hold(8'h40, 10);
    onehot_in = 8'h80;
    repeat (12) tick();
    chk("t5_no_stall_yet", 32'(stall), 32'd0);
    chk("t5_still_locked", 32'(locked), 32'd1);
    tick();
    chk("t5_stall", 32'(stall), 32'd1);
    chk("t5_unlock", 32'(locked), 32'd0);
    repeat (2) tick();
    onehot_in = 8'h01;
    tick();
    chk("t5_stall_held", 32'(stall), 32'd1);
    tick();
    chk("t5_stall_clear", 32'(stall), 32'd0);
    chk("t5_timing", 32'(timing_err), 32'd1);
    chk("t5_step", 32'(step_pulse), 32'd1);
    chk("t5_dwell", 32'(dwell_cycles), 32'd15);
    repeat (7) tick();

    phase = "t6_fast";
    hold(8'h02, 9);
    hold(8'h04, 9);
    hold(8'h08, 9);
    hold(8'h10, 9);
    onehot_in = 8'h20;
    tick(); tick();
    chk("t6_timing", 32'(timing_err), 32'd1);
    chk("t6_step", 32'(step_pulse), 32'd1);
    chk("t6_dwell", 32'(dwell_cycles), 32'd9);
    chk("t6_locked", 32'(locked), 32'd0);
    repeat (7) tick();

    phase = "random";
    for (int k = 0; k < 160; k++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      c = nxt(lastv);
      else if (r < 80) c = 8'(1 << $urandom_range(0, 7));
      else if (r < 90) c = 8'h00;
      else             c = 8'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: len = 10;
        5:             len = 9;
        6:             len = 11;
        7:             len = $urandom_range(12, 20);
        default:       len = $urandom_range(1, 8);
      endcase
      hold(c, len);
      if (k == 80) do_reset(8'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
